// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package loader_pkg;

  localparam int BYTE_W         = 8;
  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DATA  = 3'd1,
    S_WRITE = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } loader_state_t;

endpackage

// File: rtl/byte_packer.sv
// Assembles little-endian bytes into 32-bit words; word_valid flags the 4th byte.
module byte_packer
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_en,
  input  logic [BYTE_W-1:0] in_byte,
  output logic [WORD_W-1:0] word,
  output logic              word_valid
);

  logic [WORD_W-1:0] word_q, word_d;
  logic [1:0]        idx_q, idx_d;

  always_comb begin
    word_d     = word_q;
    idx_d      = idx_q;
    word_valid = 1'b0;
    if (clear) begin
      word_d = '0;
      idx_d  = '0;
    end else if (in_en) begin
      word_d[{idx_q, 3'b000} +: BYTE_W] = in_byte;
      idx_d      = idx_q + 2'd1;
      word_valid = (idx_q == 2'(BYTES_PER_WORD - 1));
    end
  end

  // The word output includes the byte being accepted so the writer can
  // register the full word on the same edge as the 4th byte.
  assign word = word_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q <= '0;
      idx_q  <= '0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Byte-stream program loader: count, little-endian words, checksum; writes
// instruction memory and releases the CPU reset on a verified load.
module program_loader
  import loader_pkg::*;
#(
  parameter int NUM_WORDS = 32,
  parameter int ADDR_W    = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              load_mem_en,
  output logic [ADDR_W-1:0] load_mem_addr,
  output logic [31:0]       load_mem_data,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [7:0] MAX_N = 8'(NUM_WORDS);

  loader_state_t     state_q, state_d;
  logic [7:0]        n_q, n_d;
  logic [7:0]        widx_q, widx_d;
  logic [7:0]        csum_q, csum_d;
  logic              load_mem_en_q, load_mem_en_d;
  logic [ADDR_W-1:0] load_mem_addr_q, load_mem_addr_d;
  logic [31:0]       load_mem_data_q, load_mem_data_d;
  logic              cpu_rst_n_q, cpu_rst_n_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              accept;
  logic              pk_clear, pk_en, pk_word_valid;
  logic [WORD_W-1:0] pk_word;

  assign in_ready = (state_q != S_WRITE);
  assign accept   = in_valid && in_ready;

  // A count byte may arrive in IDLE, DONE or ERR; each restarts the assembler.
  assign pk_clear = accept && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);
  assign pk_en    = accept && (state_q == S_DATA);

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (pk_clear),
    .in_en      (pk_en),
    .in_byte    (in_data),
    .word       (pk_word),
    .word_valid (pk_word_valid)
  );

  always_comb begin
    state_d         = state_q;
    n_d             = n_q;
    widx_d          = widx_q;
    csum_d          = csum_q;
    load_mem_en_d   = 1'b0;
    load_mem_addr_d = load_mem_addr_q;
    load_mem_data_d = load_mem_data_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (accept) begin
          n_d    = in_data;
          widx_d = '0;
          csum_d = '0;
          if (in_data == 8'd0)       state_d = S_CHECK;
          else if (in_data > MAX_N)  state_d = S_ERR;
          else                       state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          csum_d = csum_q + in_data;
          if (pk_word_valid) begin
            state_d         = S_WRITE;
            load_mem_en_d   = 1'b1;
            load_mem_addr_d = widx_q[ADDR_W-1:0];
            load_mem_data_d = pk_word;
          end
        end
      end
      S_WRITE: begin
        if (widx_q == n_q - 8'd1) begin
          state_d = S_CHECK;
        end else begin
          widx_d  = widx_q + 8'd1;
          state_d = S_DATA;
        end
      end
      S_CHECK: begin
        if (accept) state_d = (in_data == csum_q) ? S_DONE : S_ERR;
      end
      default: state_d = S_IDLE;
    endcase

    // Status flags are decoded from the next state so they are registered
    // and line up with the state they describe.
    busy_d      = (state_d == S_DATA) || (state_d == S_WRITE) || (state_d == S_CHECK);
    done_d      = (state_d == S_DONE);
    err_d       = (state_d == S_ERR);
    cpu_rst_n_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      n_q             <= '0;
      widx_q          <= '0;
      csum_q          <= '0;
      load_mem_en_q   <= 1'b0;
      load_mem_addr_q <= '0;
      load_mem_data_q <= '0;
      cpu_rst_n_q     <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      n_q             <= n_d;
      widx_q          <= widx_d;
      csum_q          <= csum_d;
      load_mem_en_q   <= load_mem_en_d;
      load_mem_addr_q <= load_mem_addr_d;
      load_mem_data_q <= load_mem_data_d;
      cpu_rst_n_q     <= cpu_rst_n_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      err_q           <= err_d;
    end
  end

  assign load_mem_en   = load_mem_en_q;
  assign load_mem_addr = load_mem_addr_q;
  assign load_mem_data = load_mem_data_q;
  assign cpu_rst_n     = cpu_rst_n_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader against a stream-level reference model.
module tb_program_loader;

  localparam int NW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready, load_mem_en, cpu_rst_n, busy, done, err;
  logic [AW-1:0] load_mem_addr;
  logic [31:0]   load_mem_data;

  program_loader #(.NUM_WORDS(NW), .ADDR_W(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .load_mem_en   (load_mem_en),
    .load_mem_addr (load_mem_addr),
    .load_mem_data (load_mem_data),
    .cpu_rst_n     (cpu_rst_n),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_cyc = 0;
  int ready_viol = 0;

  logic [7:0]    stream[$];
  logic [31:0]   exp_words[$];
  int            exp_status;   // 1 = done, 2 = err
  logic [AW-1:0] got_addr[$];
  logic [31:0]   got_data[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Record every memory write; in_ready must be low exactly when a write is in flight.
  always @(negedge clk) begin
    if (!rst) begin
      if (load_mem_en) begin
        got_addr.push_back(load_mem_addr);
        got_data.push_back(load_mem_data);
      end
      if (load_mem_en == in_ready) ready_viol++;
    end
  end

  // Reference: interpret a complete stream from its byte-level rules.
  task automatic model_run();
    int n;
    logic [7:0] sum;
    logic [31:0] w;
    exp_words.delete();
    n = int'(stream[0]);
    if (n > NW) begin
      exp_status = 2;
      return;
    end
    sum = 8'h00;
    for (int i = 0; i < n; i++) begin
      w = 32'h0;
      for (int k = 0; k < 4; k++) begin
        w = w | (32'(stream[1 + 4*i + k]) << (8*k));
        sum = sum + stream[1 + 4*i + k];
      end
      exp_words.push_back(w);
    end
    exp_status = (stream[1 + 4*n] == sum) ? 1 : 2;
  endtask

  task automatic build(input int n, input bit good);
    logic [7:0] sum, b;
    stream.delete();
    stream.push_back(8'(n));
    if (n > NW) return;
    sum = 8'h00;
    for (int i = 0; i < 4*n; i++) begin
      b = 8'($urandom);
      sum = sum + b;
      stream.push_back(b);
    end
    stream.push_back(good ? sum : sum + 8'h01);
  endtask

  // Called just after a negedge; returns just after the negedge following acceptance.
  task automatic send_byte(input logic [7:0] b);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (in_ready) begin
        @(posedge clk);
        @(negedge clk);
        acc_cyc = cyc;
        ok = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL send_byte timeout: in_ready stayed %0b, required 1", in_ready);
    end
  endtask

  task automatic send_stream(input bit gaps);
    for (int i = 0; i < stream.size(); i++) begin
      send_byte(stream[i]);
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end
    in_valid = 1'b0;
  endtask

  function automatic int write_mismatches();
    int m = 0;
    if (got_addr.size() != exp_words.size()) return 1000 + got_addr.size();
    for (int i = 0; i < exp_words.size(); i++)
      if (got_addr[i] !== AW'(i) || got_data[i] !== exp_words[i]) m++;
    return m;
  endfunction

  task automatic clear_log();
    got_addr.delete();
    got_data.delete();
    ready_viol = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({load_mem_en, load_mem_addr, load_mem_data, cpu_rst_n, busy, done, err, in_ready} !==
        {1'b0, AW'(0), 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL reset_values: en=%0b addr=%0d data=%h rstn=%0b busy=%0b done=%0b err=%0b rdy=%0b, required 0 0 0 0 0 0 0 1",
               load_mem_en, load_mem_addr, load_mem_data, cpu_rst_n, busy, done, err, in_ready);
    end
    rst = 1'b0;
    clear_log();
    repeat (10) @(negedge clk);
    total++;
    if (got_addr.size() != 0 || busy !== 1'b0 || in_ready !== 1'b1 || cpu_rst_n !== 1'b0) begin
      bad++;
      $display("FAIL idle_quiet: writes=%0d busy=%0b rdy=%0b rstn=%0b, required 0 0 1 0",
               got_addr.size(), busy, in_ready, cpu_rst_n);
    end
  endtask

  task automatic test_two_word();
    logic [7:0] b[$] = '{8'h02, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    logic [7:0] sum = 8'h00;
    clear_log();
    stream = b;
    for (int i = 1; i < b.size(); i++) sum = sum + b[i];
    stream.push_back(sum);
    model_run();
    for (int i = 0; i < stream.size() - 1; i++) send_byte(stream[i]);
    total++;
    if (cpu_rst_n !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL two_word_pre_check: rstn=%0b done=%0b busy=%0b, required 0 0 1", cpu_rst_n, done, busy);
    end
    send_byte(stream[stream.size() - 1]);
    in_valid = 1'b0;
    total++;
    if (cpu_rst_n !== 1'b1 || done !== 1'b1 || err !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL two_word_release: rstn=%0b done=%0b err=%0b busy=%0b, required 1 1 0 0", cpu_rst_n, done, err, busy);
    end
    total++;
    if (write_mismatches() != 0 || got_data.size() != 2 || got_data[0] !== 32'h12345678 || got_data[1] !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL two_word_writes: count=%0d mismatches=%0d, required 2 writes 12345678 deadbeef",
               got_data.size(), write_mismatches());
    end
  endtask

  task automatic test_bad_checksum();
    logic [7:0] b[$] = '{8'h02, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    logic [7:0] sum = 8'h00;
    clear_log();
    stream = b;
    for (int i = 1; i < b.size(); i++) sum = sum + b[i];
    stream.push_back(sum + 8'h01);
    model_run();
    send_stream(1'b0);
    total++;
    if (err !== 1'b1 || cpu_rst_n !== 1'b0 || done !== 1'b0 || got_addr.size() != 2 || write_mismatches() != 0) begin
      bad++;
      $display("FAIL bad_checksum: err=%0b rstn=%0b done=%0b writes=%0d, required 1 0 0 2",
               err, cpu_rst_n, done, got_addr.size());
    end
    clear_log();
    send_byte(8'h00);
    send_byte(8'h00);
    in_valid = 1'b0;
    total++;
    if (done !== 1'b1 || cpu_rst_n !== 1'b1 || err !== 1'b0 || got_addr.size() != 0) begin
      bad++;
      $display("FAIL empty_load: done=%0b rstn=%0b err=%0b writes=%0d, required 1 1 0 0",
               done, cpu_rst_n, err, got_addr.size());
    end
  endtask

  task automatic test_oversize();
    clear_log();
    send_byte(8'(NW + 1));
    in_valid = 1'b0;
    total++;
    if (err !== 1'b1 || cpu_rst_n !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL oversize: err=%0b rstn=%0b done=%0b busy=%0b, required 1 0 0 0", err, cpu_rst_n, done, busy);
    end
    repeat (3) @(negedge clk);
    total++;
    if (got_addr.size() != 0 || err !== 1'b1) begin
      bad++;
      $display("FAIL oversize_quiet: writes=%0d err=%0b, required 0 1", got_addr.size(), err);
    end
  endtask

  task automatic test_back_to_back();
    int first_cyc;
    clear_log();
    build(NW, 1'b1);
    model_run();
    send_byte(stream[0]);
    send_byte(stream[1]);
    first_cyc = acc_cyc;
    for (int i = 2; i < stream.size(); i++) send_byte(stream[i]);
    in_valid = 1'b0;
    total++;
    if (acc_cyc - first_cyc != 5 * NW) begin
      bad++;
      $display("FAIL full_throughput: cycles=%0d, required %0d", acc_cyc - first_cyc, 5 * NW);
    end
    total++;
    if (write_mismatches() != 0) begin
      bad++;
      $display("FAIL full_writes: count=%0d mismatches=%0d, required %0d writes", got_addr.size(),
               write_mismatches(), exp_words.size());
    end
    total++;
    if (got_addr.size() == 0 || got_addr[got_addr.size() - 1] !== AW'(NW - 1)) begin
      bad++;
      $display("FAIL full_last_addr: writes=%0d, required last addr %0d", got_addr.size(), NW - 1);
    end
    total++;
    if (ready_viol != 0 || done !== 1'b1 || cpu_rst_n !== 1'b1) begin
      bad++;
      $display("FAIL full_ready_status: ready_viol=%0d done=%0b rstn=%0b, required 0 1 1", ready_viol, done, cpu_rst_n);
    end
  endtask

  task automatic test_reset_mid();
    clear_log();
    build(2, 1'b1);
    for (int i = 0; i < 7; i++) send_byte(stream[i]);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    total++;
    if ({load_mem_en, load_mem_addr, load_mem_data, cpu_rst_n, busy, done, err, in_ready} !==
        {1'b0, AW'(0), 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL reset_mid_values: en=%0b addr=%0d data=%h rstn=%0b busy=%0b done=%0b err=%0b rdy=%0b, required 0 0 0 0 0 0 0 1",
               load_mem_en, load_mem_addr, load_mem_data, cpu_rst_n, busy, done, err, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    clear_log();
    build(3, 1'b1);
    model_run();
    send_stream(1'b0);
    total++;
    if (write_mismatches() != 0 || done !== 1'b1 || cpu_rst_n !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_reload: writes=%0d mismatches=%0d done=%0b rstn=%0b, required 3 0 1 1",
               got_addr.size(), write_mismatches(), done, cpu_rst_n);
    end
  endtask

  task automatic test_random();
    int n;
    bit good;
    for (int it = 0; it < 8; it++) begin
      clear_log();
      n = $urandom_range(0, NW + 2);
      good = 1'($urandom_range(0, 1));
      build(n, good);
      model_run();
      send_stream(1'b1);
      total++;
      if (write_mismatches() != 0 || done !== (exp_status == 1) || err !== (exp_status == 2) ||
          cpu_rst_n !== (exp_status == 1) || ready_viol != 0) begin
        bad++;
        $display("FAIL random_load n=%0d: writes=%0d mismatches=%0d done=%0b err=%0b rstn=%0b viol=%0d, required writes=%0d status=%0d",
                 n, got_addr.size(), write_mismatches(), done, err, cpu_rst_n, ready_viol, exp_words.size(), exp_status);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_two_word();
    test_bad_checksum();
    test_oversize();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
